// File: rtl/rd_resp_arbiter_if.sv
// Handshake bundle between the two read-response requesters, the arbiter
// and the ROB/response side, plus the debug beat counters.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

interface rd_resp_arbiter_if #(
  parameter int unsigned WDATA_WIDTH = `AXI_ADDR_WIDTH + `AXI_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH   = 16
);
  logic                   hit_valid_i;
  logic                   hit_ready_o;
  logic [WDATA_WIDTH-1:0] hit_wdata_i;
  logic                   miss_valid_i;
  logic                   miss_ready_o;
  logic [WDATA_WIDTH-1:0] miss_wdata_i;
  logic                   out_valid_o;
  logic                   out_ready_i;
  logic [WDATA_WIDTH-1:0] out_wdata_o;
  logic                   out_src_o;
  logic [CNT_WIDTH-1:0]   hit_cnt_o;
  logic [CNT_WIDTH-1:0]   miss_cnt_o;

  // Arbiter side
  modport slave (
    input  hit_valid_i, hit_wdata_i, miss_valid_i, miss_wdata_i, out_ready_i,
    output hit_ready_o, miss_ready_o, out_valid_o, out_wdata_o, out_src_o,
    hit_cnt_o, miss_cnt_o
  );

  // Requester / consumer side
  modport master (
    output hit_valid_i, hit_wdata_i, miss_valid_i, miss_wdata_i, out_ready_i,
    input  hit_ready_o, miss_ready_o, out_valid_o, out_wdata_o, out_src_o,
    hit_cnt_o, miss_cnt_o
  );
endinterface

// File: rtl/rd_resp_arbiter.sv
// Burst-limited round-robin arbiter sharing the read-response path between
// the read-hit path (source 0) and the read-miss handler (source 1), with a
// one-entry registered output stage and per-source beat counters.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif
`ifndef AXI_DATA_WIDTH
`define AXI_DATA_WIDTH 32
`endif

module rd_resp_arbiter #(
  parameter int unsigned ADDR_WIDTH  = `AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH  = `AXI_DATA_WIDTH,
  parameter int unsigned WDATA_WIDTH = ADDR_WIDTH + DATA_WIDTH,
  parameter int unsigned MAX_BURST   = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic               clk,
  input  logic               rst,
  rd_resp_arbiter_if.slave   bus
);

  typedef enum logic {SRC_HIT = 1'b0, SRC_MISS = 1'b1} src_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_BURST);

  logic                   out_valid_q;
  logic [WDATA_WIDTH-1:0] out_wdata_q;
  src_e                   out_src_q;
  logic [CNT_WIDTH-1:0]   hit_cnt_q;
  logic [CNT_WIDTH-1:0]   miss_cnt_q;
  src_e                   last_q;
  logic [3:0]             burst_q;

  logic                   slot_free;
  logic                   any_valid;
  logic                   accept;
  src_e                   win_src;
  src_e                   other_src;
  logic [ADDR_WIDTH-1:0]  win_addr;
  logic [DATA_WIDTH-1:0]  win_data;
  logic [WDATA_WIDTH-1:0] win_word;

  assign slot_free = !out_valid_q || bus.out_ready_i;
  assign any_valid = bus.hit_valid_i || bus.miss_valid_i;
  assign accept    = slot_free && any_valid;
  assign other_src = (last_q == SRC_HIT) ? SRC_MISS : SRC_HIT;

  // Grant selection and winner word from the valids, last pointer and burst count
  always_comb begin
    win_src = SRC_HIT;
    if (bus.hit_valid_i && bus.miss_valid_i) begin
      // burst_q is zero only straight after reset: no run is in progress, so
      // the tie goes to the source opposite the pointer (the hit path).
      if (burst_q == '0 || burst_q == BURST_MAX) begin
        win_src = other_src;
      end else begin
        win_src = last_q;
      end
    end else if (bus.miss_valid_i) begin
      win_src = SRC_MISS;
    end
    win_word = (win_src == SRC_MISS) ? bus.miss_wdata_i : bus.hit_wdata_i;
    win_addr = win_word[WDATA_WIDTH-1:DATA_WIDTH];
    win_data = win_word[DATA_WIDTH-1:0];
  end

  assign bus.hit_ready_o  = accept && (win_src == SRC_HIT);
  assign bus.miss_ready_o = accept && (win_src == SRC_MISS);

  // Output stage, burst tracking and beat counters
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_wdata_q <= '0;
      out_src_q   <= SRC_HIT;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      last_q      <= SRC_MISS;
      burst_q     <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_wdata_q <= {win_addr, win_data};
      out_src_q   <= win_src;
      if (win_src == last_q) begin
        if (burst_q != BURST_MAX) burst_q <= burst_q + 4'd1;
      end else begin
        burst_q <= 4'd1;
        last_q  <= win_src;
      end
      if (win_src == SRC_MISS) miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
      else                     hit_cnt_q  <= hit_cnt_q + CNT_WIDTH'(1);
    end else if (bus.out_ready_i) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid_o = out_valid_q;
  assign bus.out_wdata_o = out_wdata_q;
  assign bus.out_src_o   = out_src_q;
  assign bus.hit_cnt_o   = hit_cnt_q;
  assign bus.miss_cnt_o  = miss_cnt_q;

endmodule
